// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;
  typedef enum logic {IDLE, RUN} state_t;

  localparam int AW_DEF = 6;
  localparam int BW_DEF = 3;
  localparam int CW_DEF = $clog2(AW_DEF);

  function automatic int cnt_w(input int aw);
    return (aw > 1) ? $clog2(aw) : 1;
  endfunction
endpackage

// File: rtl/divisor_paso.sv
// One restoring division step: shift a dividend bit into P, subtract b if it fits.
module divisor_paso #(
  parameter int BW = 3
) (
  input  logic [BW:0]   p_i,
  input  logic          bit_i,
  input  logic [BW-1:0] b_i,
  output logic [BW:0]   p_o,
  output logic          q_o
);
  logic [BW:0] sh;
  logic [BW:0] bx;

  always_comb begin
    sh  = {p_i[BW-1:0], bit_i};
    bx  = {1'b0, b_i};
    q_o = (sh >= bx);
    p_o = q_o ? (sh - bx) : sh;
  end
endmodule

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// DIVISOR_ZERO_CHECK_EN adds a div_zero flag and a one-cycle b=0 fast path.
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] q,
  output logic [BW-1:0] r
`ifdef DIVISOR_ZERO_CHECK_EN
  ,
  output logic          div_zero
`endif
);
  localparam int CW = cnt_w(AW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [BW:0]   p_q, p_d;
  logic [BW:0]   p_nx;
  logic [AW-1:0] quo_q, quo_d;
  logic [AW-1:0] q_q, q_d;
  logic [BW-1:0] r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          qbit;
  logic          last;
`ifdef DIVISOR_ZERO_CHECK_EN
  logic          zero_q, zero_d;
  logic          dz_q, dz_d;
`endif

  divisor_paso #(.BW(BW)) u_paso (
    .p_i   (p_q),
    .bit_i (a_q[AW-1]),
    .b_i   (b_q),
    .p_o   (p_nx),
    .q_o   (qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last    = (cnt_q == CW'(AW - 1));
`ifdef DIVISOR_ZERO_CHECK_EN
    zero_d  = zero_q;
    dz_d    = 1'b0;
    if (zero_q) last = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIVISOR_ZERO_CHECK_EN
          zero_d  = (b == '0);
`endif
        end
      end
      RUN: begin
        a_d   = a_q << 1;
        p_d   = p_nx;
        quo_d = (quo_q << 1) | AW'(qbit);
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = quo_d;
          r_d     = p_nx[BW-1:0];
`ifdef DIVISOR_ZERO_CHECK_EN
          // b=0 bypass: same values the full run would produce
          if (zero_q) begin
            q_d  = '1;
            r_d  = a_q[BW-1:0];
            dz_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIVISOR_ZERO_CHECK_EN
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIVISOR_ZERO_CHECK_EN
      zero_q  <= zero_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
`ifdef DIVISOR_ZERO_CHECK_EN
  assign div_zero = dz_q;
`endif
endmodule
